// File: rtl/bp_piton_cfg_ctrl_if.sv
// rtl/bp_piton_cfg_ctrl_if.sv - config request/response port bundle for bp_piton_cfg_ctrl
//
// Purpose: groups the single valid/ready config request channel and the
// valid/yumi response channel into one interface.
// Signals:
//   req_v_i / req_ready_and_o  request handshake (transfer when both high)
//   req_w_i                    1 = write, 0 = read
//   req_core_i                 target core, num_core_p = broadcast
//   req_reg_i                  register index
//   req_data_i                 write data
//   resp_v_o / resp_yumi_i     response handshake
//   resp_data_o                read data (0 for writes)
// Modports: master drives requests and consumes responses, slave is the controller.
interface bp_piton_cfg_ctrl_if #(
    parameter int num_core_p   = 4,
    parameter int data_width_p = 64
);
    localparam int core_sel_width_lp = $clog2(num_core_p + 1);

    logic                         req_v_i;
    logic                         req_ready_and_o;
    logic                         req_w_i;
    logic [core_sel_width_lp-1:0] req_core_i;
    logic [2:0]                   req_reg_i;
    logic [data_width_p-1:0]      req_data_i;
    logic                         resp_v_o;
    logic                         resp_yumi_i;
    logic [data_width_p-1:0]      resp_data_o;

    modport master (
        output req_v_i, req_w_i, req_core_i, req_reg_i, req_data_i, resp_yumi_i,
        input  req_ready_and_o, resp_v_o, resp_data_o
    );

    modport slave (
        input  req_v_i, req_w_i, req_core_i, req_reg_i, req_data_i, resp_yumi_i,
        output req_ready_and_o, resp_v_o, resp_data_o
    );
endinterface

// File: rtl/bp_piton_cfg_ctrl.sv
// rtl/bp_piton_cfg_ctrl.sv - runtime per-core configuration controller with sequenced cache-mode apply
//
// Purpose: holds per-core freeze, pending/active I$ and D$ modes and domain ID,
// serves register reads/writes over the config port, and commits pending cache
// modes through a freeze -> drain -> commit -> release sequence.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   bus (slave)             config request/response port
//   core_idle_i             per-core quiesced indication
//   freeze_o                per-core freeze (register or forced by apply)
//   icache_coherent_o       active I$ mode per core, 1 = coherent
//   dcache_writethrough_o   active D$ mode per core, 1 = writethrough
//   did_o                   packed per-core domain IDs, core 0 in the low bits
//   apply_busy_o            apply sequence in progress
module bp_piton_cfg_ctrl #(
    parameter int num_core_p   = 4,
    parameter int data_width_p = 64,
    parameter int did_width_p  = 3,
    localparam int core_sel_width_lp = $clog2(num_core_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    bp_piton_cfg_ctrl_if.slave                bus,
    input  logic [num_core_p-1:0]             core_idle_i,
    output logic [num_core_p-1:0]             freeze_o,
    output logic [num_core_p-1:0]             icache_coherent_o,
    output logic [num_core_p-1:0]             dcache_writethrough_o,
    output logic [num_core_p*did_width_p-1:0] did_o,
    output logic                              apply_busy_o
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FREEZE  = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    localparam logic [core_sel_width_lp-1:0] bcast_sel_lp = core_sel_width_lp'(num_core_p);
    localparam logic [core_sel_width_lp-1:0] last_core_lp = core_sel_width_lp'(num_core_p - 1);

    state_e                       r_state, w_state_nxt;
    logic [core_sel_width_lp-1:0] r_tgt, w_tgt_nxt;
    logic                         r_bcast, w_bcast_nxt;
    logic                         w_commit;

    logic [num_core_p-1:0]  r_freeze;
    logic [num_core_p-1:0]  r_pend_i;
    logic [num_core_p-1:0]  r_pend_d;
    logic [num_core_p-1:0]  r_act_i;
    logic [num_core_p-1:0]  r_act_d;
    logic [did_width_p-1:0] r_did [num_core_p];

    logic                    r_resp_v;
    logic [data_width_p-1:0] r_resp_data;

    logic                    w_busy;
    logic                    w_is_bcast;
    logic                    w_core_valid;
    logic                    w_apply_wr;
    logic                    w_ready;
    logic                    w_fire;
    logic                    w_wr;
    logic                    w_apply_start;
    logic [num_core_p-1:0]   w_wr_hit;
    logic [num_core_p-1:0]   w_tgt_hit;
    logic                    w_force;

    logic                    w_sel_valid;
    logic                    w_sel_freeze;
    logic                    w_sel_pend_i;
    logic                    w_sel_pend_d;
    logic                    w_sel_act_i;
    logic                    w_sel_act_d;
    logic                    w_sel_idle;
    logic [did_width_p-1:0]  w_sel_did;
    logic [data_width_p-1:0] w_rd_data;

    // Write data above the widest field never reaches a register.
    logic w_unused_data;
    assign w_unused_data = &{1'b0, bus.req_data_i[data_width_p-1:did_width_p]};

    assign w_busy       = (r_state != ST_IDLE);
    assign w_is_bcast   = (bus.req_core_i == bcast_sel_lp);
    assign w_core_valid = (bus.req_core_i < bcast_sel_lp);
    assign w_apply_wr   = bus.req_v_i & bus.req_w_i & (bus.req_reg_i == 3'd4);

    // One response slot; a second apply cannot start while one is running,
    // but every other request keeps flowing.
    assign w_ready = (~r_resp_v | bus.resp_yumi_i) & ~(w_apply_wr & w_busy);
    assign w_fire  = bus.req_v_i & w_ready;
    assign w_wr    = w_fire & bus.req_w_i;

    // Acceptance already implies IDLE, so no state term is needed here.
    assign w_apply_start = w_wr & (bus.req_reg_i == 3'd4) & (w_is_bcast | w_core_valid);

    always_comb begin
        w_wr_hit  = '0;
        w_tgt_hit = '0;
        for (int c = 0; c < num_core_p; c++) begin
            w_wr_hit[c]  = w_wr & (w_is_bcast | (bus.req_core_i == core_sel_width_lp'(c)));
            w_tgt_hit[c] = (r_tgt == core_sel_width_lp'(c));
        end
    end

    // Read select: broadcast reads see core 0, out-of-range cores read as 0.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_freeze = 1'b0;
        w_sel_pend_i = 1'b0;
        w_sel_pend_d = 1'b0;
        w_sel_act_i  = 1'b0;
        w_sel_act_d  = 1'b0;
        w_sel_idle   = 1'b0;
        w_sel_did    = '0;
        for (int c = 0; c < num_core_p; c++) begin
            if ((bus.req_core_i == core_sel_width_lp'(c)) || (w_is_bcast && c == 0)) begin
                w_sel_valid  = 1'b1;
                w_sel_freeze = r_freeze[c];
                w_sel_pend_i = r_pend_i[c];
                w_sel_pend_d = r_pend_d[c];
                w_sel_act_i  = r_act_i[c];
                w_sel_act_d  = r_act_d[c];
                w_sel_idle   = core_idle_i[c];
                w_sel_did    = r_did[c];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_sel_valid) begin
            case (bus.req_reg_i)
                3'd0:    w_rd_data[0] = w_sel_freeze;
                3'd1:    w_rd_data[0] = w_sel_pend_i;
                3'd2:    w_rd_data[0] = w_sel_pend_d;
                3'd3:    w_rd_data[did_width_p-1:0] = w_sel_did;
                3'd4:    w_rd_data[0] = w_busy;
                3'd5:    w_rd_data[3:0] = {w_sel_act_d, w_sel_act_i, w_busy, w_sel_idle};
                default: w_rd_data = '0;
            endcase
        end
    end

    // Apply sequencer: state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_tgt   <= '0;
            r_bcast <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_bcast <= w_bcast_nxt;
        end
    end

    // Apply sequencer: next state. Broadcast walks cores 0..num_core_p-1,
    // running the full four-step sequence on each in turn.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_bcast_nxt = r_bcast;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_apply_start) begin
                    w_state_nxt = ST_FREEZE;
                    w_tgt_nxt   = w_is_bcast ? '0 : bus.req_core_i;
                    w_bcast_nxt = w_is_bcast;
                end
            end
            ST_FREEZE: w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (|(core_idle_i & w_tgt_hit)) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (r_bcast && (r_tgt < last_core_lp)) begin
                    w_tgt_nxt   = r_tgt + core_sel_width_lp'(1);
                    w_state_nxt = ST_FREEZE;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_bcast_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Config registers and response slot. Commit copies the registered
    // pending value, so a pending write landing in the commit cycle waits
    // for the next apply.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_freeze    <= '1;
            r_pend_i    <= '1;
            r_pend_d    <= '1;
            r_act_i     <= '1;
            r_act_d     <= '1;
            for (int c = 0; c < num_core_p; c++) begin
                r_did[c] <= '0;
            end
            r_resp_v    <= 1'b0;
            r_resp_data <= '0;
        end else begin
            for (int c = 0; c < num_core_p; c++) begin
                if (w_wr_hit[c]) begin
                    case (bus.req_reg_i)
                        3'd0:    r_freeze[c] <= bus.req_data_i[0];
                        3'd1:    r_pend_i[c] <= bus.req_data_i[0];
                        3'd2:    r_pend_d[c] <= bus.req_data_i[0];
                        3'd3:    r_did[c]    <= bus.req_data_i[did_width_p-1:0];
                        default: ;
                    endcase
                end
                if (w_commit && w_tgt_hit[c]) begin
                    r_act_i[c] <= r_pend_i[c];
                    r_act_d[c] <= r_pend_d[c];
                end
            end
            if (w_fire) begin
                r_resp_v    <= 1'b1;
                r_resp_data <= bus.req_w_i ? '0 : w_rd_data;
            end else if (bus.resp_yumi_i) begin
                r_resp_v    <= 1'b0;
            end
        end
    end

    // Forced freeze covers the target until RELEASE, independent of freeze_r.
    assign w_force = (r_state == ST_FREEZE) | (r_state == ST_DRAIN) | (r_state == ST_COMMIT);

    assign freeze_o              = r_freeze | ({num_core_p{w_force}} & w_tgt_hit);
    assign icache_coherent_o     = r_act_i;
    assign dcache_writethrough_o = r_act_d;
    assign apply_busy_o          = w_busy;

    always_comb begin
        did_o = '0;
        for (int c = 0; c < num_core_p; c++) begin
            did_o[c*did_width_p +: did_width_p] = r_did[c];
        end
    end

    assign bus.req_ready_and_o = w_ready;
    assign bus.resp_v_o        = r_resp_v;
    assign bus.resp_data_o     = r_resp_data;
endmodule
